// File: rtl/key_debounce_pulse.sv
// Push-button conditioner: 2-flop synchronizer, 4-state debounce FSM with a stability
// counter, and registered single-cycle press/release pulses plus a debounced level.
module key_debounce_pulse #(
  parameter int unsigned CNT_MAX    = 1000000,
  parameter int unsigned CNT_W      = 20,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic iKey,
  output logic oKeyState,
  output logic oPressPulse,
  output logic oReleasePulse
);

  localparam logic             REL_LVL  = ACTIVE_LOW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s2_q;
  logic             key_q, key_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             k;

  // Synchronizer resets to the released level so a held key is seen as a fresh press.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= REL_LVL;
      s2_q <= REL_LVL;
    end else begin
      s1_q <= iKey;
      s2_q <= s1_q;
    end
  end

  assign k = s2_q ^ ACTIVE_LOW;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      key_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        key_d = 1'b0;
        if (k) begin
          state_d = StPressWait;
        end
      end
      StPressWait: begin
        if (!k) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = StPressed;
          cnt_d   = '0;
          press_d = 1'b1;
          key_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StPressed: begin
        cnt_d = '0;
        key_d = 1'b1;
        if (!k) begin
          state_d = StReleaseWait;
        end
      end
      StReleaseWait: begin
        if (k) begin
          state_d = StPressed;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = StIdle;
          cnt_d     = '0;
          release_d = 1'b1;
          key_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        key_d   = 1'b0;
      end
    endcase
  end

  assign oKeyState     = key_q;
  assign oPressPulse   = press_q;
  assign oReleasePulse = release_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse: expected pulse edges are queued when stimulus is driven
// and popped by a monitor when the DUT raises a pulse.
module tb_key_debounce_pulse;

  logic CLK = 1'b0;
  logic rst_n = 1'b1;
  logic iKey = 1'b1;
  logic oKeyState, oPressPulse, oReleasePulse;

  int n_pass = 0;
  int n_total = 0;
  int edge_cnt = 0;
  int press_seen = 0;
  bit mon_en = 1'b0;
  int press_q[$];
  int release_q[$];

  key_debounce_pulse #(
    .CNT_MAX   (4),
    .CNT_W     (3),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .iKey         (iKey),
    .oKeyState    (oKeyState),
    .oPressPulse  (oPressPulse),
    .oReleasePulse(oReleasePulse)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_cnt++;

  // Pulse monitor: every pulse must match a queued expectation at the exact edge.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (oPressPulse || oReleasePulse) begin
        n_total++;
        if (oPressPulse && oReleasePulse)
          $display("FAIL pulse_overlap: got press=1 release=1 at edge %0d, required not both",
                   edge_cnt);
        else n_pass++;
      end
      if (oPressPulse) begin
        int e;
        press_seen++;
        n_total++;
        if (press_q.size() == 0) begin
          $display("FAIL press_unexpected: got press pulse at edge %0d, required none",
                   edge_cnt);
        end else begin
          e = press_q.pop_front();
          if (edge_cnt !== e)
            $display("FAIL press_edge: got edge %0d, required edge %0d", edge_cnt, e);
          else n_pass++;
        end
      end
      if (oReleasePulse) begin
        int e;
        n_total++;
        if (release_q.size() == 0) begin
          $display("FAIL release_unexpected: got release pulse at edge %0d, required none",
                   edge_cnt);
        end else begin
          e = release_q.pop_front();
          if (edge_cnt !== e)
            $display("FAIL release_edge: got edge %0d, required edge %0d", edge_cnt, e);
          else n_pass++;
        end
      end
    end
  end

  // Called at a falling edge; the next rising edge is the first to sample the press.
  task automatic press_key(input string tag);
    iKey = 1'b0;
    press_q.push_back(edge_cnt + 7);
    for (int i = 1; i <= 7; i++) begin
      @(negedge CLK);
      n_total++;
      if (oKeyState !== 1'(i == 7))
        $display("FAIL %s_state: cycle %0d got %b required %b", tag, i, oKeyState, i == 7);
      else n_pass++;
    end
    repeat (3) @(negedge CLK);
    n_total++;
    if (press_q.size() != 0)
      $display("FAIL %s_missing: got %0d pending press pulses, required 0", tag, press_q.size());
    else n_pass++;
  endtask

  task automatic release_key(input string tag);
    iKey = 1'b1;
    release_q.push_back(edge_cnt + 7);
    for (int i = 1; i <= 7; i++) begin
      @(negedge CLK);
      n_total++;
      if (oKeyState !== 1'(i != 7))
        $display("FAIL %s_state: cycle %0d got %b required %b", tag, i, oKeyState, i != 7);
      else n_pass++;
    end
    repeat (3) @(negedge CLK);
    n_total++;
    if (release_q.size() != 0)
      $display("FAIL %s_missing: got %0d pending release pulses, required 0", tag,
               release_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    iKey = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_total++;
    if ({oKeyState, oPressPulse, oReleasePulse} !== 3'b000)
      $display("FAIL reset_async: got %b required 000", {oKeyState, oPressPulse, oReleasePulse});
    else n_pass++;
    @(negedge CLK);
    iKey = 1'b1;
    @(negedge CLK);
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      n_total++;
      if (oKeyState !== 1'b0)
        $display("FAIL reset_idle_state: cycle %0d got %b required 0", i, oKeyState);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    press_key("clean_press");
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      n_total++;
      if (oKeyState !== 1'b1)
        $display("FAIL hold_state: cycle %0d got %b required 1", i, oKeyState);
      else n_pass++;
    end
  endtask

  task automatic test_clean_release();
    release_key("clean_release");
  endtask

  task automatic test_bouncy_press();
    for (int i = 0; i < 12; i++) begin
      iKey = ((i / 2) % 2) != 0;
      @(negedge CLK);
      n_total++;
      if (oKeyState !== 1'b0)
        $display("FAIL bounce_state: cycle %0d got %b required 0", i, oKeyState);
      else n_pass++;
    end
    press_key("bouncy_press");
    release_key("bouncy_release");
  endtask

  task automatic test_release_bounce();
    press_key("rb_press");
    iKey = 1'b1;
    repeat (3) @(negedge CLK);
    iKey = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      n_total++;
      if (oKeyState !== 1'b1)
        $display("FAIL rel_bounce_state: cycle %0d got %b required 1", i, oKeyState);
      else n_pass++;
    end
    release_key("rb_release");
  endtask

  task automatic test_reset_midop();
    press_key("midop_press");
    @(negedge CLK);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({oKeyState, oPressPulse, oReleasePulse} !== 3'b000)
      $display("FAIL midop_reset: got %b required 000", {oKeyState, oPressPulse, oReleasePulse});
    else n_pass++;
    @(negedge CLK);
    rst_n = 1'b1;
    // Key still held: debounced again from idle.
    press_key("held_through_reset");
    release_key("midop_release");
  endtask

  task automatic test_back_to_back();
    int seen0;
    seen0 = press_seen;
    for (int n = 0; n < 9; n++) begin
      press_key("b2b_press");
      release_key("b2b_release");
    end
    n_total++;
    if (press_seen - seen0 !== 9)
      $display("FAIL b2b_count: got %0d press pulses required 9", press_seen - seen0);
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at edge %0d, required completion", edge_cnt);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean_press();
    test_clean_release();
    test_bouncy_press();
    test_release_bounce();
    test_reset_midop();
    test_back_to_back();
    repeat (5) @(negedge CLK);
    n_total++;
    if (press_q.size() + release_q.size() != 0)
      $display("FAIL final_queues: got %0d pending pulses required 0",
               press_q.size() + release_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
